sram_controller: RTL and testbench

Multi-cycle controller between the MEM stage of the ARM pipeline and the board's 16-bit asynchronous SRAM. It accepts one 32-bit load or store per request, splits it into two sequenced halfword accesses, and holds each access for a programmable number of cycles. It drives `ready` low for the whole transaction so the hazard/freeze logic stalls every pipeline stage until the memory result is valid.

---
 rtl/sram_controller_if.sv | 20 ++
 rtl/sram_controller.sv | 161 ++++++++++++++++
 tb/tb_sram_controller.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_if.sv
// Pipeline-side request/response bundle between the MEM stage and the
// SRAM controller. The MEM stage is the master and the controller the slave.
interface sram_controller_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        ready;

    modport master (
        output rd_en, wr_en, address, writeData,
        input  readData, ready
    );

    modport slave (
        input  rd_en, wr_en, address, writeData,
        output readData, ready
    );
endinterface

// File: rtl/sram_controller.sv
// Multi-cycle bridge from the MEM stage to a 16-bit asynchronous SRAM.
// Each 32-bit load/store becomes two halfword accesses (low half, then high
// half), each held on the SRAM bus for ACCESS_CYCLES cycles. ready stays low
// for the whole transaction so the pipeline freezes until the result is valid.
module sram_controller #(
    parameter logic [31:0] BASE_ADDR     = 32'd1024,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    sram_controller_if.slave   bus,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [17:0]        SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N
);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    // Count value on the final cycle of each halfword phase.
    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic [3:0]  cnt;

    // Transaction captured in IDLE; later input changes are ignored.
    logic [16:0] word_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic [15:0] rdata_lo;

    logic [31:0] addr_off;
    logic [16:0] word_in;
    logic        request;
    logic        last;
    logic        in_access;
    logic        half_hi;
    logic        drive_dq;
    logic [15:0] dq_out;
    logic        unused_addr_bits;

    assign request  = bus.rd_en | bus.wr_en;

    // Word index relative to the SRAM window; wraps modulo 2^32 and the
    // byte offset within the word is dropped.
    assign addr_off = bus.address - BASE_ADDR;
    assign word_in  = addr_off[18:2];
    assign unused_addr_bits = ^{addr_off[31:19], addr_off[1:0]};

    assign last     = (cnt == LAST_CNT);

    // Chip is permanently selected with both byte lanes and outputs enabled;
    // direction is controlled by SRAM_WE_N alone.
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    assign dq_out  = half_hi ? wdata_q[31:16] : wdata_q[15:0];
    assign SRAM_DQ = drive_dq ? dq_out : 16'hzzzz;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and SRAM bus / ready outputs.
    always_comb begin
        // NOTE: every output is given a default first so no path through the
        // case statement can leave a value unassigned and infer a latch.
        next_state = state;
        bus.ready  = 1'b0;
        SRAM_ADDR  = '0;
        in_access  = 1'b0;
        half_hi    = 1'b0;

        unique case (state)
            IDLE: begin
                bus.ready = ~request;
                if (request) begin
                    next_state = LOW;
                end
            end
            LOW: begin
                in_access = 1'b1;
                SRAM_ADDR = {word_q, 1'b0};
                if (last) begin
                    next_state = HIGH;
                end
            end
            HIGH: begin
                in_access = 1'b1;
                half_hi   = 1'b1;
                SRAM_ADDR = {word_q, 1'b1};
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                bus.ready  = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        SRAM_WE_N = ~(write_q & in_access);
        drive_dq  = write_q & in_access;
    end

    // Per-phase cycle counter; restarts at the start of each halfword phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if ((state == LOW) || (state == HIGH)) begin
            cnt <= last ? 4'd0 : cnt + 4'd1;
        end else begin
            cnt <= '0;
        end
    end

    // Request capture and low-half read data holding registers.
    always_ff @(posedge clk) begin
        // NOTE: these holding registers carry no reset; they are always
        // loaded before use, and only control state needs a known value.
        if ((state == IDLE) && request) begin
            word_q  <= word_in;
            wdata_q <= bus.writeData;
            write_q <= bus.wr_en;
        end
        if ((state == LOW) && last && !write_q) begin
            rdata_lo <= SRAM_DQ;
        end
    end

    // Load result: updated only as DONE is entered after a read.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.readData <= '0;
        end else if ((state == HIGH) && last && !write_q) begin
            bus.readData <= {SRAM_DQ, rdata_lo};
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: directed and random loads/stores
// against a word-level memory model, scoreboard checked by a monitor, plus
// reset-abort and latency checks at ACCESS_CYCLES of 1 and 4.
module tb_sram_controller;

    localparam int          N    = 2;
    localparam logic [31:0] BASE = 32'd1024;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sram_controller_if bus  ();
    sram_controller_if bus1 ();
    sram_controller_if bus4 ();

    wire  [15:0] sram_dq;
    wire  [15:0] dq1;
    wire  [15:0] dq4;
    logic [17:0] sram_addr;
    logic [17:0] addr1;
    logic [17:0] addr4;
    logic        sram_we_n;
    logic        we1;
    logic        we4;
    logic [2:0]  ub_n;
    logic [2:0]  lb_n;
    logic [2:0]  ce_n;
    logic [2:0]  oe_n;

    sram_controller #(.BASE_ADDR(BASE), .ACCESS_CYCLES(N)) u_dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n),
        .SRAM_UB_N(ub_n[0]), .SRAM_LB_N(lb_n[0]), .SRAM_CE_N(ce_n[0]), .SRAM_OE_N(oe_n[0])
    );

    sram_controller #(.BASE_ADDR(BASE), .ACCESS_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave),
        .SRAM_DQ(dq1), .SRAM_ADDR(addr1), .SRAM_WE_N(we1),
        .SRAM_UB_N(ub_n[1]), .SRAM_LB_N(lb_n[1]), .SRAM_CE_N(ce_n[1]), .SRAM_OE_N(oe_n[1])
    );

    sram_controller #(.BASE_ADDR(BASE), .ACCESS_CYCLES(4)) u_dut4 (
        .clk(clk), .reset(reset), .bus(bus4.slave),
        .SRAM_DQ(dq4), .SRAM_ADDR(addr4), .SRAM_WE_N(we4),
        .SRAM_UB_N(ub_n[2]), .SRAM_LB_N(lb_n[2]), .SRAM_CE_N(ce_n[2]), .SRAM_OE_N(oe_n[2])
    );

    // ---------------- board SRAM model (main instance) ----------------
    logic [15:0] sram_mem [0:262143];

    function automatic logic [15:0] init_pattern(input int h);
        return 16'(h * 7 + 3);
    endfunction

    always @(posedge clk) begin
        if (!sram_we_n) sram_mem[sram_addr] <= sram_dq;
    end
    assign sram_dq = sram_we_n ? sram_mem[sram_addr] : 16'hzzzz;

    // Latency instances: the SRAM returns a fixed function of the address.
    assign dq1 = we1 ? (addr1[15:0] ^ 16'h5A5A) : 16'hzzzz;
    assign dq4 = we4 ? (addr4[15:0] ^ 16'h5A5A) : 16'hzzzz;

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [int];
    logic [31:0] last_read;

    function automatic logic [15:0] ref_read(input int h);
        if (ref_mem.exists(h)) return ref_mem[h];
        return init_pattern(h);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] d;
        d = a - BASE;
        return int'(d >> 2) & 32'h1FFFF;
    endfunction

    typedef struct {
        bit          is_write;
        logic [31:0] rd;
        int          word;
        logic [15:0] lo;
        logic [15:0] hi;
    } exp_t;

    exp_t sb[$];

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: counts frozen cycles per transaction and scores each one at
    // the cycle ready returns high.
    initial begin
        int   low_cnt;
        int   we_cnt;
        exp_t e;
        low_cnt = 0;
        we_cnt  = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                low_cnt = 0;
                we_cnt  = 0;
            end else if (!bus.ready) begin
                low_cnt++;
                if (!sram_we_n) we_cnt++;
            end else if (low_cnt > 0) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", low_cnt, 0);
                end else begin
                    e = sb.pop_front();
                    check("ready_low_cycles", low_cnt, 2 * N + 1);
                    check("we_low_cycles", we_cnt, e.is_write ? 2 * N : 0);
                    check("readData", bus.readData, e.rd);
                    check("done_sram_addr", sram_addr, 0);
                    check("done_we_n", sram_we_n, 1);
                    if (e.is_write) begin
                        check("sram_lo", sram_mem[2 * e.word], e.lo);
                        check("sram_hi", sram_mem[2 * e.word + 1], e.hi);
                    end
                end
                low_cnt = 0;
                we_cnt  = 0;
            end
        end
    end

    // Issue one request on the main instance and hold it until ready.
    task automatic issue(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        int   k;
        e.is_write = wr;
        e.word     = word_of(addr);
        e.lo       = data[15:0];
        e.hi       = data[31:16];
        if (wr) begin
            ref_mem[2 * e.word]     = data[15:0];
            ref_mem[2 * e.word + 1] = data[31:16];
            e.rd = last_read;
        end else begin
            e.rd = {ref_read(2 * e.word + 1), ref_read(2 * e.word)};
            last_read = e.rd;
        end
        sb.push_back(e);

        @(posedge clk); #1;
        bus.rd_en     = rd;
        bus.wr_en     = wr;
        bus.address   = addr;
        bus.writeData = data;
        for (k = 0; k < 64; k++) begin
            @(negedge clk);
            if (bus.ready) break;
        end
        if (k == 64) check("ready_timeout", bus.ready, 1);
        @(posedge clk); #1;
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    // Stimulus.
    initial begin
        int cnt;
        reset          = 1'b1;
        bus.rd_en      = 1'b0;  bus.wr_en  = 1'b0;
        bus.address    = '0;    bus.writeData  = '0;
        bus1.rd_en     = 1'b0;  bus1.wr_en = 1'b0;
        bus1.address   = '0;    bus1.writeData = '0;
        bus4.rd_en     = 1'b0;  bus4.wr_en = 1'b0;
        bus4.address   = '0;    bus4.writeData = '0;
        last_read      = '0;
        for (int i = 0; i < 262144; i++) sram_mem[i] = init_pattern(i);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_readData", bus.readData, 0);
        check("rst_ready", bus.ready, 1);
        check("rst_we_n", sram_we_n, 1);
        check("rst_sram_addr", sram_addr, 0);

        // Directed scenarios.
        issue(0, 1, BASE,        32'hDEADBEEF);
        issue(1, 0, BASE,        32'h0);
        issue(0, 1, BASE + 4,    32'h12345678);
        issue(0, 1, BASE + 7,    32'hCAFEF00D);
        issue(1, 0, BASE,        32'h0);          // [0]/[1] untouched
        issue(1, 1, BASE,        32'hA5A5A5A5);   // both high: write, readData held
        issue(1, 0, BASE + 4,    32'h0);
        issue(1, 0, BASE + 2,    32'h0);
        issue(0, 1, BASE - 4,    32'h0BADF00D);   // wraps to the top SRAM word
        issue(1, 0, BASE - 3,    32'h0);

        // Randomized traffic over a small window.
        for (int t = 0; t < 24; t++) begin
            int          op;
            logic [31:0] a;
            op = int'($urandom_range(0, 2));
            a  = BASE + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            issue(op != 1, op != 0, a, $urandom);
        end

        cnt = 0;
        while (sb.size() != 0 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("scoreboard_drained", sb.size(), 0);

        // Reset in the middle of the HIGH phase of a read.
        issue(1, 0, BASE + 4, 32'h0);
        @(posedge clk); #1;
        bus.rd_en   = 1'b1;
        bus.address = BASE;
        repeat (N + 1) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_readData", bus.readData, 0);
        check("abort_we_n", sram_we_n, 1);
        check("abort_sram_addr", sram_addr, 0);
        @(posedge clk); #1 bus.rd_en = 1'b0;
        @(negedge clk);
        check("abort_ready", bus.ready, 1);
        @(posedge clk); #1 reset = 1'b0;
        last_read = '0;
        issue(1, 0, BASE, 32'h0);

        // Latency with ACCESS_CYCLES = 1.
        @(posedge clk); #1;
        bus1.rd_en   = 1'b1;
        bus1.address = BASE + 8;
        cnt = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (bus1.ready) break;
            cnt++;
        end
        check("n1_ready_low", cnt, 3);
        check("n1_readData", bus1.readData, {16'd5 ^ 16'h5A5A, 16'd4 ^ 16'h5A5A});
        @(posedge clk); #1 bus1.rd_en = 1'b0;

        // Latency with ACCESS_CYCLES = 4.
        @(posedge clk); #1;
        bus4.rd_en   = 1'b1;
        bus4.address = BASE + 12;
        cnt = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (bus4.ready) break;
            cnt++;
        end
        check("n4_ready_low", cnt, 9);
        check("n4_readData", bus4.readData, {16'd7 ^ 16'h5A5A, 16'd6 ^ 16'h5A5A});
        @(posedge clk); #1 bus4.rd_en = 1'b0;

        repeat (3) @(posedge clk);
        check("final_scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
